// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end. Issues sequential ICCM reads,
// queues returned {instr, pc} pairs and presents the head entry to decode.
// Reads are reserved against queue space so a response always has a slot.
module fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN-1:0]      reset_vector,
  output logic [XLEN-1:0]      mem_addr,
  output logic                 mem_addr_valid,
  output logic [TAG_WIDTH-1:0] mem_tag_out,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_rdata_valid,
  input  logic [TAG_WIDTH-1:0] mem_tag_in,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  output logic [XLEN-1:0]      instr_tag,
  input  logic                 pipe_stall,
  input  logic                 flush,
  input  logic [XLEN-1:0]      flush_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW:0]   FULL_SUM = (CW + 1)'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two and at least 2");
  end

  logic [XLEN-1:0]      fetch_pc;
  logic [31:0]          q_instr [DEPTH];
  logic [TAG_WIDTH-1:0] q_tag   [DEPTH];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [CW-1:0]        count;
  logic [CW-1:0]        inflight;
  logic [CW-1:0]        discard;

  logic [CW:0]          occupancy;
  logic                 issue;
  logic                 push;
  logic                 pop;

  // Request/handshake decode; rst_n gates issue so nothing is requested while held in reset
  always_comb begin
    occupancy      = {1'b0, count} + {1'b0, inflight};
    issue          = rst_n && !flush && (occupancy < FULL_SUM);
    push           = mem_rdata_valid && !flush && (discard == '0);
    instr_valid    = (count != '0) && !flush;
    pop            = instr_valid && !pipe_stall;
    mem_addr_valid = issue;
    mem_addr       = fetch_pc;
    mem_tag_out    = TAG_WIDTH'(fetch_pc);
    instr          = q_instr[head];
    instr_tag      = XLEN'(q_tag[head]);
  end

  // PC, pointers and occupancy counters; flush overrides every other update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= reset_vector;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
    end else if (flush) begin
      fetch_pc <= flush_pc;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      // Every read still outstanding after this cycle belongs to the old path
      inflight <= inflight - CW'(mem_rdata_valid);
      discard  <= inflight - CW'(mem_rdata_valid);
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end

      case ({issue, mem_rdata_valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      if (mem_rdata_valid && (discard != '0)) begin
        discard <= discard - 1'b1;
      end

      if (push) begin
        tail <= tail + 1'b1;
      end

      if (pop) begin
        head <= head + 1'b1;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage; cleared on reset so the head reads as zero until filled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_tag[i]   <= '0;
      end
    end else if (push) begin
      q_instr[tail] <= mem_rdata;
      q_tag[tail]   <= mem_tag_in;
    end
  end

  // Reservation at issue time must make a full-queue push impossible
  push_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count == FULL)));

  // Responses only ever answer a request that is still outstanding
  rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rdata_valid |-> (inflight != '0));

  // Outstanding reads plus queued entries never exceed the queue size
  occupancy_bound: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= FULL_SUM);

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue against a one-cycle ICCM model.
// Inputs change 1ns after posedge; outputs are sampled on the negedge.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] reset_vector;
  logic [31:0] mem_addr;
  logic        mem_addr_valid;
  logic [31:0] mem_tag_out;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic [31:0] mem_tag_in;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] instr_tag;
  logic        pipe_stall;
  logic        flush;
  logic [31:0] flush_pc;

  int tests    = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .XLEN(32), .TAG_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .reset_vector   (reset_vector),
    .mem_addr       (mem_addr),
    .mem_addr_valid (mem_addr_valid),
    .mem_tag_out    (mem_tag_out),
    .mem_rdata      (mem_rdata),
    .mem_rdata_valid(mem_rdata_valid),
    .mem_tag_in     (mem_tag_in),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_tag      (instr_tag),
    .pipe_stall     (pipe_stall),
    .flush          (flush),
    .flush_pc       (flush_pc)
  );

  // ICCM model: answers every request one cycle later, data = addr ^ 0xDEAD0000
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rdata_valid <= 1'b0;
      mem_rdata       <= '0;
      mem_tag_in      <= '0;
    end else begin
      mem_rdata_valid <= mem_addr_valid;
      mem_rdata       <= mem_addr ^ 32'hDEAD_0000;
      mem_tag_in      <= mem_tag_out;
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Assert reset (possibly mid-run), check reset outputs, release at start of cycle C0
  task automatic do_reset(input logic [31:0] vec);
    rst_n        = 1'b0;
    flush        = 1'b0;
    flush_pc     = '0;
    pipe_stall   = 1'b0;
    reset_vector = vec;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_addr_valid", {31'd0, mem_addr_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_tag", instr_tag, 32'd0);
    chk("rst_addr", mem_addr, vec);
    nc();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Boot and steady streaming
    do_reset(32'h0000_0100);
    smp();
    chk("c0_addr_valid", {31'd0, mem_addr_valid}, 32'd1);
    chk("c0_addr", mem_addr, 32'h0000_0100);
    chk("c0_tag_out", mem_tag_out, 32'h0000_0100);
    chk("c0_instr_valid", {31'd0, instr_valid}, 32'd0);
    nc(); smp();
    chk("c1_addr", mem_addr, 32'h0000_0104);
    chk("c1_instr_valid", {31'd0, instr_valid}, 32'd0);
    nc(); smp();
    chk("c2_instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("c2_instr_tag", instr_tag, 32'h0000_0100);
    chk("c2_instr", instr, 32'hDEAD_0100);
    chk("c2_addr", mem_addr, 32'h0000_0108);
    nc(); smp();
    chk("c3_instr_tag", instr_tag, 32'h0000_0104);
    chk("c3_instr_valid", {31'd0, instr_valid}, 32'd1);
    nc(); smp();
    chk("c4_instr_tag", instr_tag, 32'h0000_0108);
    chk("c4_instr", instr, 32'hDEAD_0108);

    // Stall for ten cycles: queue fills, requests stop, head holds
    do_reset(32'h0000_0100);
    pipe_stall = 1'b1;
    smp();
    repeat (4) nc();
    smp();
    chk("stall_c4_addr_valid", {31'd0, mem_addr_valid}, 32'd0);
    repeat (5) nc();
    smp();
    chk("stall_c9_addr_valid", {31'd0, mem_addr_valid}, 32'd0);
    chk("stall_c9_instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("stall_c9_instr_tag", instr_tag, 32'h0000_0100);
    nc();
    pipe_stall = 1'b0;
    smp();
    chk("drain_tag0", instr_tag, 32'h0000_0100);
    for (int k = 1; k <= 4; k++) begin
      nc(); smp();
      chk("drain_valid", {31'd0, instr_valid}, 32'd1);
      chk("drain_tag", instr_tag, 32'h0000_0100 + 32'(4 * k));
    end

    // Flush with three queued entries and one read returning
    do_reset(32'h0000_0100);
    pipe_stall = 1'b1;
    smp();
    repeat (4) nc();
    flush    = 1'b1;
    flush_pc = 32'h0000_0200;
    smp();
    chk("fl1_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("fl1_addr_valid", {31'd0, mem_addr_valid}, 32'd0);
    nc();
    flush      = 1'b0;
    pipe_stall = 1'b0;
    smp();
    chk("fl1_next_addr", mem_addr, 32'h0000_0200);
    chk("fl1_next_addr_valid", {31'd0, mem_addr_valid}, 32'd1);
    chk("fl1_empty_a", {31'd0, instr_valid}, 32'd0);
    nc(); smp();
    chk("fl1_empty_b", {31'd0, instr_valid}, 32'd0);
    nc(); smp();
    chk("fl1_first_valid", {31'd0, instr_valid}, 32'd1);
    chk("fl1_first_tag", instr_tag, 32'h0000_0200);
    chk("fl1_first_instr", instr, 32'hDEAD_0200);

    // Flush coinciding with a response and a would-be pop
    do_reset(32'h0000_0100);
    smp();
    repeat (3) nc();
    flush    = 1'b1;
    flush_pc = 32'h0000_0280;
    smp();
    chk("fl2_instr_valid", {31'd0, instr_valid}, 32'd0);
    nc();
    flush = 1'b0;
    smp();
    chk("fl2_next_addr", mem_addr, 32'h0000_0280);
    chk("fl2_empty_a", {31'd0, instr_valid}, 32'd0);
    nc(); smp();
    chk("fl2_empty_b", {31'd0, instr_valid}, 32'd0);
    nc(); smp();
    chk("fl2_first_tag", instr_tag, 32'h0000_0280);
    chk("fl2_first_valid", {31'd0, instr_valid}, 32'd1);
    nc(); smp();
    chk("fl2_second_tag", instr_tag, 32'h0000_0284);

    // Two consecutive flushes: the later target wins
    do_reset(32'h0000_0100);
    smp();
    repeat (3) nc();
    flush    = 1'b1;
    flush_pc = 32'h0000_0300;
    smp();
    chk("fl3_a_instr_valid", {31'd0, instr_valid}, 32'd0);
    nc();
    flush_pc = 32'h0000_0400;
    smp();
    chk("fl3_b_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("fl3_b_addr_valid", {31'd0, mem_addr_valid}, 32'd0);
    nc();
    flush = 1'b0;
    smp();
    chk("fl3_next_addr", mem_addr, 32'h0000_0400);
    chk("fl3_empty_a", {31'd0, instr_valid}, 32'd0);
    nc(); smp();
    chk("fl3_empty_b", {31'd0, instr_valid}, 32'd0);
    nc(); smp();
    chk("fl3_first_tag", instr_tag, 32'h0000_0400);
    chk("fl3_first_valid", {31'd0, instr_valid}, 32'd1);

    // PC wraps past the top of the address space
    do_reset(32'hFFFF_FFFC);
    smp();
    chk("wrap_c0_addr", mem_addr, 32'hFFFF_FFFC);
    nc(); smp();
    chk("wrap_c1_addr", mem_addr, 32'h0000_0000);
    nc(); smp();
    chk("wrap_c2_tag", instr_tag, 32'hFFFF_FFFC);
    chk("wrap_c2_instr", instr, 32'h2152_FFFC);
    nc(); smp();
    chk("wrap_c3_tag", instr_tag, 32'h0000_0000);
    chk("wrap_c3_instr", instr, 32'hDEAD_0000);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
